// File: rtl/multicycle_alu.sv
// multicycle_alu: registered EX-stage ALU. Logic, add/sub, compare, shift and LUI
// complete in one cycle; unsigned multiply (shift-add) and divide (restoring)
// iterate one bit per cycle. Results are presented as a HI/LO pair with a done pulse.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for start; single-cycle ops complete from here
//   S_MUL  | shift-add multiply iterations in progress, busy high
//   S_DIV  | restoring divide iterations in progress, busy high
module multicycle_alu #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH),
   parameter int CNT_W   = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [3:0]         ALUOperation,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   input  logic [SHAMT_W-1:0] ALUShamt,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   ALUResult,
   output logic [WIDTH-1:0]   ALUResultHi,
   output logic               Zero,
   output logic               DivByZero
);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_NOR  = 4'b0010;
   localparam logic [3:0] OP_ADD  = 4'b0011;
   localparam logic [3:0] OP_SLL  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_ADDI = 4'b0110;
   localparam logic [3:0] OP_ORI  = 4'b0111;
   localparam logic [3:0] OP_LUI  = 4'b1000;
   localparam logic [3:0] OP_ANDI = 4'b1001;
   localparam logic [3:0] OP_SUB  = 4'b1010;
   localparam logic [3:0] OP_SLT  = 4'b1011;
   localparam logic [3:0] OP_SRA  = 4'b1100;
   localparam logic [3:0] OP_MULTU = 4'b1101;
   localparam logic [3:0] OP_DIVU = 4'b1110;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_hi;     // product high half / partial remainder
   logic [WIDTH-1:0] r_lo;     // multiplier shifting out, product low bits / quotient
   logic [WIDTH-1:0] r_opnd;   // multiplicand or divisor
   logic [CNT_W-1:0] r_cnt;

   logic [WIDTH-1:0] w_res;
   logic             w_slt;
   logic             w_is_div;
   logic [WIDTH-1:0] w_hi_in;
   logic [WIDTH-1:0] w_lo_in;
   logic [WIDTH-1:0] w_opnd_in;
   logic [WIDTH:0]   w_mul_sum;
   logic [WIDTH:0]   w_div_shift;
   logic [WIDTH-1:0] w_div_diff;
   logic             w_div_ge;
   logic [WIDTH-1:0] w_hi_nx;
   logic [WIDTH-1:0] w_lo_nx;

   assign w_slt = ($signed(A) < $signed(B));

   // single-cycle result, evaluated straight from the live inputs while idle
   always_comb begin
      w_res = '0;
      case (ALUOperation)
         OP_AND, OP_ANDI: w_res = A & B;
         OP_OR,  OP_ORI:  w_res = A | B;
         OP_NOR:          w_res = ~(A | B);
         OP_ADD, OP_ADDI: w_res = A + B;
         OP_SLL:          w_res = A << ALUShamt;
         OP_SRL:          w_res = A >> ALUShamt;
         OP_LUI:          w_res = B << (WIDTH / 2);
         OP_SUB:          w_res = A - B;
         OP_SLT:          w_res = {{(WIDTH-1){1'b0}}, w_slt};
         OP_SRA:          w_res = $unsigned($signed(A) >>> ALUShamt);
         default:         w_res = '0;
      endcase
   end

   // one multiply/divide iteration; in IDLE it runs on the freshly loaded operands
   // so the launch edge already performs the first of the WIDTH iterations
   always_comb begin
      if (r_state == S_IDLE) begin
         w_is_div  = (ALUOperation == OP_DIVU);
         w_hi_in   = '0;
         w_lo_in   = w_is_div ? A : B;
         w_opnd_in = w_is_div ? B : A;
      end else begin
         w_is_div  = (r_state == S_DIV);
         w_hi_in   = r_hi;
         w_lo_in   = r_lo;
         w_opnd_in = r_opnd;
      end
      w_mul_sum   = {1'b0, w_hi_in} + (w_lo_in[0] ? {1'b0, w_opnd_in} : '0);
      w_div_shift = {w_hi_in, w_lo_in[WIDTH-1]};
      w_div_ge    = (w_div_shift >= {1'b0, w_opnd_in});
      // remainder stays below the divisor, so the low WIDTH bits hold the true difference
      w_div_diff  = w_div_shift[WIDTH-1:0] - w_opnd_in;
      if (w_is_div) begin
         w_hi_nx = w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
         w_lo_nx = {w_lo_in[WIDTH-2:0], w_div_ge};
      end else begin
         w_hi_nx = w_mul_sum[WIDTH:1];
         w_lo_nx = {w_mul_sum[0], w_lo_in[WIDTH-1:1]};
      end
   end

   // control FSM with registered outputs; reset aborts any iteration silently
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_hi        <= '0;
         r_lo        <= '0;
         r_opnd      <= '0;
         r_cnt       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         ALUResult   <= '0;
         ALUResultHi <= '0;
         Zero        <= 1'b1;
         DivByZero   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (ALUOperation == OP_MULTU) begin
                     r_hi    <= w_hi_nx;
                     r_lo    <= w_lo_nx;
                     r_opnd  <= A;
                     r_cnt   <= CNT_W'(WIDTH - 1);
                     busy    <= 1'b1;
                     r_state <= S_MUL;
                  end else if (ALUOperation == OP_DIVU && B != '0) begin
                     r_hi    <= w_hi_nx;
                     r_lo    <= w_lo_nx;
                     r_opnd  <= B;
                     r_cnt   <= CNT_W'(WIDTH - 1);
                     busy    <= 1'b1;
                     r_state <= S_DIV;
                  end else if (ALUOperation == OP_DIVU) begin
                     ALUResult   <= '1;
                     ALUResultHi <= A;
                     Zero        <= 1'b0;
                     DivByZero   <= 1'b1;
                     done        <= 1'b1;
                  end else begin
                     ALUResult   <= w_res;
                     ALUResultHi <= '0;
                     Zero        <= (w_res == '0);
                     DivByZero   <= 1'b0;
                     done        <= 1'b1;
                  end
               end
            end
            S_MUL, S_DIV: begin
               r_hi  <= w_hi_nx;
               r_lo  <= w_lo_nx;
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  ALUResult   <= w_lo_nx;
                  ALUResultHi <= w_hi_nx;
                  Zero        <= (w_lo_nx == '0);
                  DivByZero   <= 1'b0;
                  done        <= 1'b1;
                  busy        <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: directed and randomized checks of multicycle_alu at WIDTH=32 and WIDTH=16.
module tb_multicycle_alu;

   logic clk;
   logic reset;

   logic        start32, busy32, done32, zero32, dbz32;
   logic [3:0]  op32;
   logic [31:0] a32, b32, res32, hi32;
   logic [4:0]  sh32;

   logic        start16, busy16, done16, zero16, dbz16;
   logic [3:0]  op16;
   logic [15:0] a16, b16, res16, hi16;
   logic [3:0]  sh16;

   int checks = 0;
   int errors = 0;

   multicycle_alu #(.WIDTH(32)) dut32 (
      .clk(clk), .reset(reset), .start(start32), .ALUOperation(op32),
      .A(a32), .B(b32), .ALUShamt(sh32), .busy(busy32), .done(done32),
      .ALUResult(res32), .ALUResultHi(hi32), .Zero(zero32), .DivByZero(dbz32)
   );

   multicycle_alu #(.WIDTH(16)) dut16 (
      .clk(clk), .reset(reset), .start(start16), .ALUOperation(op16),
      .A(a16), .B(b16), .ALUShamt(sh16), .busy(busy16), .done(done16),
      .ALUResult(res16), .ALUResultHi(hi16), .Zero(zero16), .DivByZero(dbz16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference behaviour for a w-bit ALU, written with plain integer arithmetic
   function automatic void ref_alu(input int w, input logic [3:0] op,
                                   input logic [31:0] a_in, input logic [31:0] b_in,
                                   input int sh, output logic [31:0] lo,
                                   output logic [31:0] hi, output logic dbz);
      logic [63:0] mask, a, b, p;
      longint sa, sb;
      mask = (64'd1 << w) - 64'd1;
      a = {32'd0, a_in} & mask;
      b = {32'd0, b_in} & mask;
      sa = a[w-1] ? (longint'(a) - (longint'(1) << w)) : longint'(a);
      sb = b[w-1] ? (longint'(b) - (longint'(1) << w)) : longint'(b);
      p = 64'd0;
      hi = 32'd0;
      dbz = 1'b0;
      case (op)
         4'd0, 4'd9:  p = a & b;
         4'd1, 4'd7:  p = a | b;
         4'd2:        p = ~(a | b);
         4'd3, 4'd6:  p = a + b;
         4'd4:        p = a << sh;
         4'd5:        p = a >> sh;
         4'd8:        p = b << (w / 2);
         4'd10:       p = a - b;
         4'd11:       p = (sa < sb) ? 64'd1 : 64'd0;
         4'd12:       p = 64'(sa >>> sh);
         4'd13: begin
            p  = a * b;
            hi = 32'((p >> w) & mask);
         end
         4'd14: begin
            if (b == 64'd0) begin
               p   = mask;
               hi  = 32'(a);
               dbz = 1'b1;
            end else begin
               p  = a / b;
               hi = 32'(a % b);
            end
         end
         default:     p = 64'd0;
      endcase
      lo = 32'(p & mask);
   endfunction

   task automatic launch32(input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] sh);
      @(negedge clk);
      op32 = op; a32 = a; b32 = b; sh32 = sh; start32 = 1'b1;
      @(posedge clk);
      #1;
      start32 = 1'b0;
      op32 = 4'($urandom); a32 = $urandom; b32 = $urandom; sh32 = 5'($urandom);
   endtask

   task automatic launch16(input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [3:0] sh);
      @(negedge clk);
      op16 = op; a16 = a; b16 = b; sh16 = sh; start16 = 1'b1;
      @(posedge clk);
      #1;
      start16 = 1'b0;
      op16 = 4'($urandom); a16 = 16'($urandom); b16 = 16'($urandom); sh16 = 4'($urandom);
   endtask

   // lat = number of edges from the start-sampling edge to done (1 = next cycle), -1 on timeout;
   // busy_bad counts samples where busy disagreed with "high before done, low on done"
   task automatic wait_done32(input int budget, output int lat, output int busy_bad);
      lat = -1;
      busy_bad = 0;
      for (int k = 1; k <= budget; k++) begin
         if (k > 1) begin @(posedge clk); #1; end
         if (done32) begin
            lat = k;
            if (busy32) busy_bad++;
            break;
         end
         if (!busy32) busy_bad++;
      end
   endtask

   task automatic wait_done16(input int budget, output int lat, output int busy_bad);
      lat = -1;
      busy_bad = 0;
      for (int k = 1; k <= budget; k++) begin
         if (k > 1) begin @(posedge clk); #1; end
         if (done16) begin
            lat = k;
            if (busy16) busy_bad++;
            break;
         end
         if (!busy16) busy_bad++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start32 = 1'b0; op32 = '0; a32 = '0; b32 = '0; sh32 = '0;
      start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; sh16 = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy32); end
      checks++; if (done32 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done32); end
      checks++; if (res32 !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", res32); end
      checks++; if (hi32 !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi32); end
      checks++; if (zero32 !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b want 1", zero32); end
      checks++; if (dbz32 !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", dbz32); end
      checks++; if (zero16 !== 1'b1 || busy16 !== 1'b0) begin errors++; $display("FAIL reset_16: zero %b busy %b want 1 0", zero16, busy16); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_add();
      int lat, bb;
      launch32(4'b0011, 32'd5, 32'd7, 5'd0);
      wait_done32(4, lat, bb);
      checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency: got %0d want 1", lat); end
      checks++; if (res32 !== 32'd12) begin errors++; $display("FAIL add_result: got %0d want 12", res32); end
      checks++; if (zero32 !== 1'b0) begin errors++; $display("FAIL add_zero: got %b want 0", zero32); end
      checks++; if (bb !== 0) begin errors++; $display("FAIL add_busy: got %0d bad samples want 0", bb); end
      @(posedge clk); #1;
      checks++; if (done32 !== 1'b0) begin errors++; $display("FAIL add_done_pulse: got %b want 0", done32); end
      checks++; if (res32 !== 32'd12) begin errors++; $display("FAIL add_hold: got %0d want 12", res32); end
   endtask

   task automatic test_single_cycle_ops();
      int lat, bb;
      launch32(4'b1010, 32'd3, 32'd3, 5'd0);
      wait_done32(4, lat, bb);
      checks++; if (res32 !== 32'd0 || zero32 !== 1'b1) begin errors++; $display("FAIL sub_zero: got %h/%b want 0/1", res32, zero32); end
      launch32(4'b1011, 32'hFFFF_FFFF, 32'd1, 5'd0);
      wait_done32(4, lat, bb);
      checks++; if (res32 !== 32'd1) begin errors++; $display("FAIL slt_signed: got %h want 1", res32); end
      launch32(4'b1100, 32'h8000_0000, 32'd0, 5'd4);
      wait_done32(4, lat, bb);
      checks++; if (res32 !== 32'hF800_0000) begin errors++; $display("FAIL sra: got %h want f8000000", res32); end
      launch32(4'b1000, 32'd0, 32'h0000_1234, 5'd0);
      wait_done32(4, lat, bb);
      checks++; if (res32 !== 32'h1234_0000) begin errors++; $display("FAIL lui: got %h want 12340000", res32); end
      launch32(4'b1111, 32'h1234, 32'h5678, 5'd3);
      wait_done32(4, lat, bb);
      checks++; if (lat !== 1 || res32 !== 32'd0 || hi32 !== 32'd0) begin errors++; $display("FAIL undef_op: lat %0d res %h hi %h want 1 0 0", lat, res32, hi32); end
   endtask

   task automatic test_multu();
      int lat, bb;
      launch32(4'b1101, 32'hFFFF_FFFF, 32'd2, 5'd0);
      wait_done32(40, lat, bb);
      checks++; if (lat !== 32) begin errors++; $display("FAIL multu_latency: got %0d want 32", lat); end
      checks++; if (hi32 !== 32'd1 || res32 !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_result: got %h_%h want 00000001_fffffffe", hi32, res32); end
      checks++; if (bb !== 0) begin errors++; $display("FAIL multu_busy: got %0d bad samples want 0", bb); end
      @(posedge clk); #1;
      checks++; if (done32 !== 1'b0) begin errors++; $display("FAIL multu_done_pulse: got %b want 0", done32); end
   endtask

   task automatic test_divu();
      int lat, bb;
      launch32(4'b1110, 32'd100, 32'd7, 5'd0);
      wait_done32(40, lat, bb);
      checks++; if (lat !== 32) begin errors++; $display("FAIL divu_latency: got %0d want 32", lat); end
      checks++; if (res32 !== 32'd14 || hi32 !== 32'd2 || dbz32 !== 1'b0) begin errors++; $display("FAIL divu_result: got q %0d r %0d dbz %b want 14 2 0", res32, hi32, dbz32); end
      launch32(4'b1110, 32'd9, 32'd0, 5'd0);
      wait_done32(40, lat, bb);
      checks++; if (lat !== 1) begin errors++; $display("FAIL div0_latency: got %0d want 1", lat); end
      checks++; if (res32 !== 32'hFFFF_FFFF || hi32 !== 32'd9 || dbz32 !== 1'b1 || zero32 !== 1'b0) begin errors++; $display("FAIL div0_result: got %h %h dbz %b zero %b want ffffffff 9 1 0", res32, hi32, dbz32, zero32); end
   endtask

   task automatic test_start_while_busy();
      int first = -1;
      int ndone = 0;
      logic [31:0] lo_seen = '0, hi_seen = '0;
      launch32(4'b1101, 32'hFFFF_FFFF, 32'd2, 5'd0);
      for (int k = 1; k <= 40; k++) begin
         if (k > 1) begin @(posedge clk); #1; end
         if (done32) begin
            ndone++;
            if (first < 0) begin first = k; lo_seen = res32; hi_seen = hi32; end
         end
         if (k == 5) begin op32 = 4'b0011; a32 = 32'd1; b32 = 32'd1; start32 = 1'b1; end
         if (k == 6) start32 = 1'b0;
      end
      checks++; if (ndone !== 1 || first !== 32) begin errors++; $display("FAIL busy_ignore_done: got %0d dones first at %0d want 1 at 32", ndone, first); end
      checks++; if (lo_seen !== 32'hFFFF_FFFE || hi_seen !== 32'd1) begin errors++; $display("FAIL busy_ignore_result: got %h_%h want 00000001_fffffffe", hi_seen, lo_seen); end
   endtask

   task automatic test_reset_mid_op();
      int lat, bb;
      int ndone = 0;
      launch32(4'b1110, 32'd100, 32'd7, 5'd0);
      repeat (9) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      checks++; if (busy32 !== 1'b0 || done32 !== 1'b0 || res32 !== 32'd0 || hi32 !== 32'd0 || zero32 !== 1'b1 || dbz32 !== 1'b0) begin
         errors++; $display("FAIL abort_outputs: busy %b done %b res %h hi %h zero %b dbz %b want 0 0 0 0 1 0", busy32, done32, res32, hi32, zero32, dbz32);
      end
      reset = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (done32) ndone++;
      end
      checks++; if (ndone !== 0) begin errors++; $display("FAIL abort_no_done: got %0d dones want 0", ndone); end
      launch32(4'b0011, 32'd20, 32'd22, 5'd0);
      wait_done32(4, lat, bb);
      checks++; if (lat !== 1 || res32 !== 32'd42) begin errors++; $display("FAIL abort_recover: lat %0d res %0d want 1 42", lat, res32); end
   endtask

   task automatic test_back_to_back();
      int lat, bb;
      launch32(4'b1101, 32'd3, 32'd5, 5'd0);
      wait_done32(40, lat, bb);
      checks++; if (lat !== 32 || res32 !== 32'd15 || hi32 !== 32'd0) begin errors++; $display("FAIL b2b_first: lat %0d res %0d hi %0d want 32 15 0", lat, res32, hi32); end
      op32 = 4'b0011; a32 = 32'd10; b32 = 32'd20; start32 = 1'b1;
      @(posedge clk); #1;
      start32 = 1'b0;
      checks++; if (done32 !== 1'b1 || res32 !== 32'd30) begin errors++; $display("FAIL b2b_second: done %b res %0d want 1 30", done32, res32); end
   endtask

   task automatic test_random32();
      int lat, bb, exp_lat;
      logic [3:0] op;
      logic [31:0] a, b, elo, ehi;
      logic edbz;
      logic [4:0] sh;
      for (int i = 0; i < 60; i++) begin
         op = 4'($urandom_range(0, 15));
         a = $urandom;
         b = $urandom;
         sh = 5'($urandom);
         if (op == 4'd14) begin
            case ($urandom_range(0, 2))
               0: b = 32'd0;
               1: b = $urandom_range(1, 300);
               default: ;
            endcase
         end
         ref_alu(32, op, a, b, int'(sh), elo, ehi, edbz);
         exp_lat = (op == 4'd13 || (op == 4'd14 && b != 32'd0)) ? 32 : 1;
         launch32(op, a, b, sh);
         wait_done32(40, lat, bb);
         checks++;
         if (lat !== exp_lat || bb !== 0 || res32 !== elo || hi32 !== ehi || dbz32 !== edbz || zero32 !== (elo == 32'd0)) begin
            errors++;
            $display("FAIL rand32 op %h a %h b %h sh %0d: got lat %0d busybad %0d lo %h hi %h dbz %b zero %b want lat %0d lo %h hi %h dbz %b",
                     op, a, b, sh, lat, bb, res32, hi32, dbz32, zero32, exp_lat, elo, ehi, edbz);
         end
      end
   endtask

   task automatic test_random16();
      int lat, bb, exp_lat;
      logic [3:0] op, sh;
      logic [15:0] a, b;
      logic [31:0] elo, ehi;
      logic edbz;
      for (int i = 0; i < 60; i++) begin
         op = 4'($urandom_range(0, 15));
         a = 16'($urandom);
         b = 16'($urandom);
         sh = 4'($urandom);
         if (op == 4'd14) begin
            case ($urandom_range(0, 2))
               0: b = 16'd0;
               1: b = 16'($urandom_range(1, 40));
               default: ;
            endcase
         end
         ref_alu(16, op, {16'd0, a}, {16'd0, b}, int'(sh), elo, ehi, edbz);
         exp_lat = (op == 4'd13 || (op == 4'd14 && b != 16'd0)) ? 16 : 1;
         launch16(op, a, b, sh);
         wait_done16(24, lat, bb);
         checks++;
         if (lat !== exp_lat || bb !== 0 || {16'd0, res16} !== elo || {16'd0, hi16} !== ehi || dbz16 !== edbz || zero16 !== (elo == 32'd0)) begin
            errors++;
            $display("FAIL rand16 op %h a %h b %h sh %0d: got lat %0d busybad %0d lo %h hi %h dbz %b zero %b want lat %0d lo %h hi %h dbz %b",
                     op, a, b, sh, lat, bb, res16, hi16, dbz16, zero16, exp_lat, elo[15:0], ehi[15:0], edbz);
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_single_cycle_ops();
      test_multu();
      test_divu();
      test_start_while_busy();
      test_reset_mid_op();
      test_back_to_back();
      test_random32();
      test_random16();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
